// File: rtl/branch_predict_ctrl_pkg.sv
// rtl/branch_predict_ctrl_pkg.sv - shared widths and counter encodings for the branch predictor
package branch_predict_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int CTR_W  = 2;

  // 2-bit saturating predictor states: strongly/weakly not-taken, weakly/strongly taken
  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Entries come out of reset weakly not-taken; fresh allocations start weakly taken
  localparam ctr_e CTR_RST   = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  // Tag covers every PC bit above the index and the word offset
  function automatic int tag_w(input int idx_w);
    return ADDR_W - idx_w - 2;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_bp_sat_counter.sv
// rtl/branch_predict_ctrl_bp_sat_counter.sv - 2-bit saturating up/down next-state function
module bp_sat_counter
  import branch_predict_ctrl_pkg::*;
(
  input  ctr_e cur,
  input  logic up,
  output ctr_e nxt
);

  logic [CTR_W-1:0] cur_bits;
  assign cur_bits = cur;

  // Step toward taken on up, toward not-taken otherwise, holding at either end
  always_comb begin
    nxt = cur;
    if (up) begin
      if (cur != ST) nxt = ctr_e'(cur_bits + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_e'(cur_bits - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - BTB/BHT branch predictor with EX-stage redirect and perf counters
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_if,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic             ex_stall,
  input  logic [31:0]      ex_pc,
  input  logic             ex_br,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = tag_w(IDX_W);

  // Flat flop arrays so the whole table clears on async reset
  logic             tab_valid  [ENTRIES];
  logic [TAG_W-1:0] tab_tag    [ENTRIES];
  logic [31:0]      tab_target [ENTRIES];
  ctr_e             tab_ctr    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic [CTR_W-1:0] if_ctr;
  ctr_e             ex_ctr_next;
  logic             upd, mis;
  logic             unused_pc_bits;

  assign if_idx = pc_if[IDX_W+1:2];
  assign if_tag = pc_if[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign unused_pc_bits = ^pc_if[1:0];

  // IF lookup reads stored state only; a same-cycle EX write is seen next cycle
  always_comb begin
    if_hit      = tab_valid[if_idx] && (tab_tag[if_idx] == if_tag);
    if_ctr      = tab_ctr[if_idx];
    pred_taken  = if_hit && if_ctr[1];
    pred_target = if_hit ? tab_target[if_idx] : 32'd0;
  end

  // EX resolution: a stall or reset holds back flush, training and counting
  always_comb begin
    upd         = rst_n && ex_valid && ex_is_br && !ex_stall;
    mis         = (ex_br != ex_pred_taken) ||
                  (ex_br && ex_pred_taken && (ex_target != ex_pred_target));
    flush       = upd && mis;
    redirect_pc = 32'd0;
    if (flush) redirect_pc = ex_br ? ex_target : ex_pc + 32'd4;
    ex_hit      = tab_valid[ex_idx] && (tab_tag[ex_idx] == ex_tag);
  end

  bp_sat_counter u_ex_ctr (
    .cur (tab_ctr[ex_idx]),
    .up  (ex_br),
    .nxt (ex_ctr_next)
  );

  // Table training: hits step the counter, taken misses allocate, not-taken misses are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tab_valid[i]  <= 1'b0;
        tab_tag[i]    <= '0;
        tab_target[i] <= 32'd0;
        tab_ctr[i]    <= CTR_RST;
      end
    end else if (upd) begin
      if (ex_hit) begin
        tab_ctr[ex_idx] <= ex_ctr_next;
        if (ex_br) tab_target[ex_idx] <= ex_target;
      end else if (ex_br) begin
        tab_valid[ex_idx]  <= 1'b1;
        tab_tag[ex_idx]    <= ex_tag;
        tab_target[ex_idx] <= ex_target;
        tab_ctr[ex_idx]    <= CTR_ALLOC;
      end
    end
  end

  // Saturating performance counters: resolved branches and mispredicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd && (br_count != '1)) br_count <= br_count + CNT_W'(1);
      if (flush && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule
